pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter XLEN, default 32: PC and address width in bits.
REQ-002 Parameter RESET_VECTOR, default 32'h00000000: PC value loaded on reset.
REQ-003 Parameter INC, default 4: sequential PC increment.
REQ-004 Parameter RAS_DEPTH, default 4: return-address-stack entries; power of two, >= 2.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 stall  input  1  hold PC and RAS this cycle.
REQ-008 redirect_valid  input  1  execute-stage correction (mispredict/trap).
REQ-009 redirect_pc  input  XLEN  correction target.
REQ-010 jump_valid  input  1  decode-stage direct jump.
REQ-011 jump_target  input  XLEN  direct jump target.
REQ-012 jump_is_call  input  1  qualifies jump_valid; push return address.
REQ-013 ret_valid  input  1  return; next PC from RAS top.
REQ-014 pc_out  output  XLEN  registered current PC.
REQ-015 pc_next  output  XLEN  combinational value pc_out takes at next edge.
REQ-016 pc_src  output  3  combinational source select (pc_src_e encoding).
REQ-017 ras_empty / ras_full  output  1 each  combinational occupancy flags.
REQ-018 ras_overflow / ras_underflow  output  1 each  registered one-cycle pulses.

Function
REQ-019 Next-PC priority SHALL be: rst > redirect_valid > stall > ret_valid > jump_valid > sequential.
REQ-020 Redirect: pc_next = redirect_pc, applied even when stall=1; RAS unchanged.
REQ-021 Stall (no redirect): pc_next = pc_out; RAS, pointers and pulses unchanged (pulses drop to 0).
REQ-022 Ret, RAS non-empty: pc_next = top entry; pop; occupancy -1.
REQ-023 Ret, RAS empty: pc_next = pc_out + INC; ras_underflow pulses 1 next cycle; occupancy stays 0.
REQ-024 Ret and jump asserted together: ret wins; jump and call push ignored.
REQ-025 Jump: pc_next = jump_target; if jump_is_call, push pc_out + INC.
REQ-026 Push when full: overwrite oldest entry (circular), occupancy stays RAS_DEPTH, ras_overflow pulses 1 next cycle.
REQ-027 jump_is_call without jump_valid SHALL be ignored.
REQ-028 Sequential: pc_next = pc_out + INC modulo 2^XLEN (all-ones - INC + 1 wraps to 0).
REQ-029 Latency: a command sampled at edge N is visible on pc_out after edge N; pc_next reflects it combinationally in the same cycle.
REQ-030 Occupancy counter width SHALL be $clog2(RAS_DEPTH)+1; ras_full when count == RAS_DEPTH, ras_empty when count == 0.

Reset
REQ-031 On rst=1 at an edge: pc_out = RESET_VECTOR, RAS pointer and count = 0, ras_overflow = ras_underflow = 0; all other inputs ignored.
REQ-032 Reset asserted mid-stall or mid-redirect SHALL take effect at that same edge; RAS contents need not be cleared, only invalidated.

Structure
REQ-033 Package pc_pkg SHALL hold enum pc_src_e {SRC_RESET, SRC_REDIRECT, SRC_HOLD, SRC_RET, SRC_JUMP, SRC_SEQ} and default constants for XLEN, INC, RESET_VECTOR.
REQ-034 The RAS SHALL be a separate sub-module ras_stack (push, pop, data in/out, empty, full, overflow, underflow), parameterised by XLEN and RAS_DEPTH.
REQ-035 Next-PC mux SHALL be a single priority-encoded combinational block driving pc_src and pc_next.

Verification
REQ-036 rst=1 one cycle, then idle 3 cycles -> pc_out 0x0, 0x4, 0x8, 0xC.
REQ-037 pc_out=0x100, jump_valid=1, jump_is_call=1, jump_target=0x400; next cycle ret_valid=1 -> pc_out 0x400 then 0x104, ras_empty=1.
REQ-038 stall=1 with pc_out=0x12345678 and jump_valid=1 -> pc_out holds 0x12345678, RAS count unchanged; same cycle redirect_valid=1, redirect_pc=0x0F0F0F0C -> pc_out 0x0F0F0F0C.
REQ-039 Five calls from 0x0,0x10,0x20,0x30,0x40 (RAS_DEPTH=4) -> ras_overflow pulses once on fifth; four rets return 0x44,0x34,0x24,0x14; fifth ret -> ras_underflow=1, pc = prev+4.
REQ-040 pc_out=0xFFFFFFFC, idle -> pc_out 0x00000000; ret_valid and jump_valid together with RAS top 0x200 -> pc_out 0x200, no push.
REQ-041 rst=1 during stall with RAS count 3 -> pc_out RESET_VECTOR, ras_empty=1, following ret -> ras_underflow=1.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and default constants for the PC fetch unit.
// The next-PC source encoding is also driven onto the pc_src status output.
package pc_pkg;

    localparam int unsigned XLEN_DEF         = 32;
    localparam int unsigned INC_DEF          = 4;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;

    typedef enum logic [2:0] {
        SRC_RESET,
        SRC_REDIRECT,
        SRC_HOLD,
        SRC_RET,
        SRC_JUMP,
        SRC_SEQ
    } pc_src_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Control and status bundle between the pipeline and the PC fetch unit.
// The master drives the control inputs; the slave (the fetch unit) drives PC and RAS status.
interface pc_fetch_unit_if
    import pc_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
);

    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            jump_valid;
    logic [XLEN-1:0] jump_target;
    logic            jump_is_call;
    logic            ret_valid;

    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] pc_next;
    pc_src_e         pc_src;
    logic            ras_empty;
    logic            ras_full;
    logic            ras_overflow;
    logic            ras_underflow;

    modport master (
        output stall, redirect_valid, redirect_pc, jump_valid, jump_target, jump_is_call,
               ret_valid,
        input  pc_out, pc_next, pc_src, ras_empty, ras_full, ras_overflow, ras_underflow
    );

    modport slave (
        input  stall, redirect_valid, redirect_pc, jump_valid, jump_target, jump_is_call,
               ret_valid,
        output pc_out, pc_next, pc_src, ras_empty, ras_full, ras_overflow, ras_underflow
    );

endinterface

// File: rtl/pc_fetch_unit_ras.sv
// Circular return-address stack.  When it is full, a push overwrites the oldest entry and
// raises overflow.  A pop from an empty stack raises underflow.  Both are one-cycle pulses.
module ras_stack #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top_data,
    output logic            empty,
    output logic            full,
    output logic            overflow,
    output logic            underflow
);

    localparam int unsigned PtrW = $clog2(RAS_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;

    // ptr_q is the next free slot; once the stack is full it also indexes the oldest entry.
    assign top_data  = mem_q[ptr_q - PtrW'(1)];
    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CntW'(RAS_DEPTH));
    assign overflow  = ovf_q;
    assign underflow = unf_q;

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (push) begin
            ptr_d = ptr_q + PtrW'(1);
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end else if (pop) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                ptr_d = ptr_q - PtrW'(1);
                cnt_d = cnt_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // The stack entries have no reset; they are invalidated through cnt_q.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter generator.  It selects the next PC from reset, redirect, stall, return,
// jump or sequential sources in that priority order, and keeps a return-address stack.
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int unsigned    XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
    parameter int unsigned    INC          = INC_DEF,
    parameter int unsigned    RAS_DEPTH    = 4
) (
    input logic               clk,
    input logic               rst,
    pc_fetch_unit_if.slave    fif
);

    logic [XLEN-1:0] pc_q, pc_d, pc_seq;
    pc_src_e         src;
    logic            ras_push, ras_pop;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty, ras_full, ras_ovf, ras_unf;

    assign pc_seq = pc_q + XLEN'(INC);

    always_comb begin
        pc_d     = pc_seq;
        src      = SRC_SEQ;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        if (rst) begin
            pc_d = RESET_VECTOR;
            src  = SRC_RESET;
        end else if (fif.redirect_valid) begin
            pc_d = fif.redirect_pc;
            src  = SRC_REDIRECT;
        end else if (fif.stall) begin
            pc_d = pc_q;
            src  = SRC_HOLD;
        end else if (fif.ret_valid) begin
            // A return with an empty stack falls through to the sequential PC.
            ras_pop = 1'b1;
            if (!ras_empty) begin
                pc_d = ras_top;
                src  = SRC_RET;
            end
        end else if (fif.jump_valid) begin
            pc_d     = fif.jump_target;
            src      = SRC_JUMP;
            ras_push = fif.jump_is_call;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_seq),
        .top_data  (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .overflow  (ras_ovf),
        .underflow (ras_unf)
    );

    assign fif.pc_out        = pc_q;
    assign fif.pc_next       = pc_d;
    assign fif.pc_src        = src;
    assign fif.ras_empty     = ras_empty;
    assign fif.ras_full      = ras_full;
    assign fif.ras_overflow  = ras_ovf;
    assign fif.ras_underflow = ras_unf;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit.  A small reference model of the PC and the RAS predicts
// each edge and queues the expected results; the results are checked after the edge.
module tb_pc_fetch_unit;
    import pc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_fetch_unit_if #(.XLEN(32)) fif ();

    pc_fetch_unit #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000),
        .INC          (4),
        .RAS_DEPTH    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .fif (fif)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        ovf;
        logic        unf;
        logic        empty;
        logic        full;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of control inputs, predict the result, check pc_next/pc_src
    // before the edge, and check the registered outputs after it.
    task automatic step(input logic r, input logic st, input logic rv, input logic [31:0] rpc,
                        input logic jv, input logic [31:0] jt, input logic call,
                        input logic ret);
        exp_t        e;
        logic [31:0] npc;
        logic [2:0]  src;
        rst                = r;
        fif.stall          = st;
        fif.redirect_valid = rv;
        fif.redirect_pc    = rpc;
        fif.jump_valid     = jv;
        fif.jump_target    = jt;
        fif.jump_is_call   = call;
        fif.ret_valid      = ret;
        e.ovf = 1'b0;
        e.unf = 1'b0;
        if (r) begin
            npc = 32'h0;
            src = SRC_RESET;
            m_ras.delete();
        end else if (rv) begin
            npc = rpc;
            src = SRC_REDIRECT;
        end else if (st) begin
            npc = m_pc;
            src = SRC_HOLD;
        end else if (ret) begin
            if (m_ras.size() > 0) begin
                npc = m_ras.pop_back();
                src = SRC_RET;
            end else begin
                npc   = m_pc + 32'd4;
                src   = SRC_SEQ;
                e.unf = 1'b1;
            end
        end else if (jv) begin
            npc = jt;
            src = SRC_JUMP;
            if (call) begin
                if (m_ras.size() == 4) begin
                    void'(m_ras.pop_front());
                    e.ovf = 1'b1;
                end
                m_ras.push_back(m_pc + 32'd4);
            end
        end else begin
            npc = m_pc + 32'd4;
            src = SRC_SEQ;
        end
        #1;
        chk("pc_next", fif.pc_next, npc);
        chk("pc_src", {29'b0, fif.pc_src}, {29'b0, src});
        e.pc    = npc;
        e.empty = (m_ras.size() == 0);
        e.full  = (m_ras.size() == 4);
        sb.push_back(e);
        m_pc = npc;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("pc_out", fif.pc_out, e.pc);
        chk("ras_overflow", {31'b0, fif.ras_overflow}, {31'b0, e.ovf});
        chk("ras_underflow", {31'b0, fif.ras_underflow}, {31'b0, e.unf});
        chk("ras_empty", {31'b0, fif.ras_empty}, {31'b0, e.empty});
        chk("ras_full", {31'b0, fif.ras_full}, {31'b0, e.full});
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic redirect(input logic [31:0] a);
        step(1'b0, 1'b0, 1'b1, a, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic call_to(input logic [31:0] t);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, t, 1'b1, 1'b0);
    endtask

    task automatic ret_op();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    initial begin
        // Reset followed by sequential fetch.
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        idle();
        idle();
        idle();
        chk("seq_after_reset", fif.pc_out, 32'h0000_000C);

        // A call and its matching return.
        redirect(32'h100);
        call_to(32'h400);
        ret_op();
        chk("call_ret_pc", fif.pc_out, 32'h104);

        // A stall holds the PC and ignores the jump; a redirect overrides the stall.
        redirect(32'h1234_5678);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h800, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h0F0F_0F0C, 1'b1, 32'h800, 1'b0, 1'b0);
        chk("stall_redirect_pc", fif.pc_out, 32'h0F0F_0F0C);

        // jump_is_call without jump_valid must not push.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h900, 1'b1, 1'b0);

        // Five calls overflow a four-deep stack, then unwind past empty.
        redirect(32'h0);
        call_to(32'h10);
        call_to(32'h20);
        call_to(32'h30);
        call_to(32'h40);
        call_to(32'h50);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        ret_op();
        ret_op();
        ret_op();
        ret_op();
        chk("deepest_ret", fif.pc_out, 32'h14);
        ret_op();
        chk("underflow_pc", fif.pc_out, 32'h18);

        // Wrap at the top of the address space, then ret takes priority over a call.
        redirect(32'hFFFF_FFFC);
        idle();
        chk("wrap_pc", fif.pc_out, 32'h0);
        redirect(32'h1FC);
        call_to(32'h500);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h600, 1'b1, 1'b1);
        chk("ret_beats_jump", fif.pc_out, 32'h200);

        // Reset during a stall with three entries on the stack.
        call_to(32'h700);
        call_to(32'h710);
        call_to(32'h720);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        ret_op();
        chk("ret_after_reset", fif.pc_out, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
